// File: rtl/aes_gf_pkg.sv
// Shared constants, enums and affine helpers for the GF(2^8) S-box engine.
package aes_gf_pkg;

    localparam logic [7:0] GF_POLY   = 8'h1B;  // x^8 + x^4 + x^3 + x + 1, low byte
    localparam logic [7:0] AFF_C     = 8'h63;  // forward affine constant
    localparam logic [7:0] INV_AFF_D = 8'h05;  // inverse affine constant
    localparam logic [2:0] ITER_LAST = 3'd6;   // iteration on which the final square happens

    typedef enum logic [1:0] {
        MODE_RAW_INV  = 2'b00,
        MODE_FWD_SBOX = 2'b01,
        MODE_INV_SBOX = 2'b10,
        MODE_RSVD     = 2'b11   // behaves like MODE_RAW_INV
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SQR  = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Forward AES affine map: b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i
    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
                 ^ a[(i + 7) % 8] ^ AFF_C[i];
        end
        return b;
    endfunction

    // Inverse AES affine map: b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ d_i
    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ INV_AFF_D[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gf_mul8.sv
// Combinational 8x8 multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
module gf_mul8
    import aes_gf_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] shifted;

    // Shift-and-add: accumulate a*x^i for every set bit of b, reducing as we go.
    always_comb begin
        p       = '0;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? GF_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/sbox_engine.sv
// Iterative GF(2^8) inverter / AES S-box engine: computes a^254 with a shared
// multiplier using 7 square and 6 multiply cycles.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid && ready are both high. in_ready is high only in IDLE, out_valid only
// in DONE; out_byte/out_valid stay stable in DONE until out_ready is seen.
module sbox_engine
    import aes_gf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic [1:0] in_mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       busy
);

    state_t     state;
    state_t     state_nxt;
    mode_t      mode;
    logic [7:0] a_reg;
    logic [7:0] acc;
    logic [7:0] out_reg;
    logic [2:0] iter;
    logic [7:0] mul_b;
    logic [7:0] prod;
    logic [7:0] operand;
    logic       accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_byte  = out_reg;
    assign accept    = in_valid && in_ready;

    // Inverse S-box undoes the affine map before inverting.
    assign operand = (in_mode == MODE_INV_SBOX) ? inv_affine(in_byte) : in_byte;

    // One multiplier: SQR computes acc*acc, MUL computes acc*a.
    assign mul_b = (state == ST_MUL) ? a_reg : acc;

    gf_mul8 u_mul (
        .a (acc),
        .b (mul_b),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_SQR;
            ST_SQR:  state_nxt = (iter == ITER_LAST) ? ST_DONE : ST_MUL;
            ST_MUL:  state_nxt = ST_SQR;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers: operand capture, accumulator, iteration count, result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode    <= MODE_RAW_INV;
            a_reg   <= '0;
            acc     <= '0;
            iter    <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode  <= mode_t'(in_mode);
                        a_reg <= operand;
                        acc   <= operand;
                        iter  <= '0;
                    end
                end
                ST_SQR: begin
                    acc <= prod;
                    if (iter == ITER_LAST) begin
                        out_reg <= (mode == MODE_FWD_SBOX) ? affine(prod) : prod;
                    end
                end
                ST_MUL: begin
                    acc  <= prod;
                    iter <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sbox_engine.md
SBOX_ENGINE -- requirements
Module: sbox_engine

Interface
REQ-001 SHALL use parameter none; all constants from aes_gf_pkg.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk is the clock and rst_n is the reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  byte offered on in_byte/in_mode.
REQ-006 in_ready  output  1  engine can accept a byte.
REQ-007 in_byte  input  8  operand.
REQ-008 in_mode  input  2  00 raw GF inverse, 01 forward S-box, 10 inverse S-box, 11 treated as 00.
REQ-009 out_valid  output  1  out_byte holds the result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_byte  output  8  result, registered.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Field: GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (xor constant 8'h1B); inverse(0) SHALL be 0.
REQ-014 States: IDLE, SQR, MUL, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready, capture operand a, mode, acc<=a, iter<=0, go SQR; otherwise hold.
REQ-016 Mode 10: captured a = inverse-affine(in_byte): b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ d_i, indices mod 8, d = 8'h05.
REQ-017 SQR: acc<=acc*acc; if iter==6 go DONE, else go MUL.
REQ-018 MUL: acc<=acc*a; iter<=iter+1; go SQR.
REQ-019 Sequence yields a^254 = a^-1: 7 SQR and 6 MUL cycles (13 compute cycles); iter is 3 bits, never exceeds 6.
REQ-020 On the final SQR, out_byte SHALL be loaded with affine(acc*acc) for mode 01: b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i, c = 8'h63; raw acc*acc for other modes.
REQ-021 Latency: acceptance cycle = cycle 0; out_valid SHALL be high from cycle 14.
REQ-022 DONE: out_byte and out_valid held stable while out_ready low; on out_ready go IDLE (in_ready high next cycle).
REQ-023 No input is accepted in SQR, MUL or DONE; in_valid there is ignored and in_byte changes have no effect.
REQ-024 Throughput: one result per 15 cycles minimum (no accept in the DONE→IDLE cycle).

Reset
REQ-025 rst_n low at a clock edge SHALL force state IDLE, acc=0, a=0, iter=0, mode=00, out_byte=0.
REQ-026 Outputs after reset: in_ready=1, out_valid=0, busy=0, out_byte=8'h00.
REQ-027 Reset mid-operation (SQR/MUL/DONE) SHALL abandon the computation with no result ever presented.
REQ-028 rst_n has priority over any simultaneous handshake.

Structure
REQ-029 aes_gf_pkg SHALL hold: GF_POLY 8'h1B, AFF_C 8'h63, INV_AFF_D 8'h05, mode enum, state enum.
REQ-030 One combinational sub-module gf_mul8 (full 8x8 GF(2^8) multiply, a,b → p) SHALL be instantiated once; SQR and MUL share it via operand muxing.
REQ-031 Affine and inverse-affine functions SHALL be package functions, combinational.

Verification
REQ-032 Reset, then in_mode=01, in_byte=8'h00 → out_byte 8'h63 with out_valid in cycle 14.
REQ-033 in_mode=00, in_byte=8'h53 → 8'hCA; in_mode=01, in_byte=8'h53 → 8'hED; in_mode=01, in_byte=8'h01 → 8'h7C.
REQ-034 in_mode=10, in_byte=8'hED → 8'h53; in_mode=10, in_byte=8'h63 → 8'h00; in_mode=11, in_byte=8'h01 → 8'h01.
REQ-035 Backpressure: out_ready low 5 cycles in DONE → out_byte stable, in_ready 0; in_valid toggling with new bytes meanwhile is not accepted.
REQ-036 Assert rst_n low in cycle 7 of a computation → cycle after: out_valid 0, in_ready 1, busy 0; no result appears.
REQ-037 Sweep all 256 bytes in modes 01 and 10 back-to-back against a golden S-box table; check InvS(S(x))==x.
